// File: rtl/dmem_if.sv
// Core and host data-memory bus for dmem_responder. Cores and host are always-accept
// masters: there is no ready, a request is taken on every clk edge it is presented.
interface dmem_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12
);
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_wr_en;
  logic [NUM_CORES*DATA_W-1:0] core_rdata;
  logic [ADDR_W-1:0]           host_addr;
  logic [DATA_W-1:0]           host_wdata;
  logic                        host_wr_en;
  logic [DATA_W-1:0]           host_rdata;

  modport master (
    output core_addr, core_wdata, core_wr_en, host_addr, host_wdata, host_wr_en,
    input  core_rdata, host_rdata
  );

  modport slave (
    input  core_addr, core_wdata, core_wr_en, host_addr, host_wdata, host_wr_en,
    output core_rdata, host_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Shared word RAM serving NUM_CORES buffered core ports plus one host port.
// Optional own-buffer read forwarding is enabled by defining DMEM_RAW_FWD_EN.
module dmem_responder #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_if.slave                bus,
  output logic                 wbuf_empty,
  output logic [NUM_CORES-1:0] overflow
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] fifo_addr_mem [NUM_CORES][WBUF_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [NUM_CORES][WBUF_DEPTH];

  logic [PTR_W-1:0]     rd_ptr_q [NUM_CORES], rd_ptr_d [NUM_CORES];
  logic [PTR_W-1:0]     wr_ptr_q [NUM_CORES], wr_ptr_d [NUM_CORES];
  logic [CNT_W-1:0]     count_q  [NUM_CORES], count_d  [NUM_CORES];
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_CORES-1:0] overflow_q, overflow_d;
  logic [DATA_W-1:0]    core_rdata_q [NUM_CORES], core_rdata_d [NUM_CORES];
  logic [DATA_W-1:0]    host_rdata_q, host_rdata_d;

  logic [NUM_CORES-1:0] push, pop;
  logic                 grant_vld;
  logic [RR_W-1:0]      grant;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_waddr;
  logic [DATA_W-1:0]    ram_wdata;

  // Round-robin search starting at rr_q; first non-empty buffer wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = rr_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_q) + k) % NUM_CORES;
      if (!grant_vld && count_q[idx] != '0) begin
        grant_vld = 1'b1;
        grant     = RR_W'(idx);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (!bus.host_wr_en && grant_vld) rr_d = RR_W'((int'(grant) + 1) % NUM_CORES);
    for (int i = 0; i < NUM_CORES; i++) begin
      pop[i]        = !bus.host_wr_en && grant_vld && (int'(grant) == i);
      push[i]       = bus.core_wr_en[i] && ((count_q[i] < CNT_W'(WBUF_DEPTH)) || pop[i]);
      count_d[i]    = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      wr_ptr_d[i]   = wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i]   = rd_ptr_q[i] + PTR_W'(pop[i]);
      overflow_d[i] = overflow_q[i] | (bus.core_wr_en[i] & ~push[i]);
    end
  end

  // Host writes take the single RAM write port ahead of any buffer drain.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = bus.host_addr;
    ram_wdata = bus.host_wdata;
    if (bus.host_wr_en) begin
      ram_we = 1'b1;
    end else if (grant_vld) begin
      ram_we    = 1'b1;
      ram_waddr = fifo_addr_mem[grant][rd_ptr_q[grant]];
      ram_wdata = fifo_data_mem[grant][rd_ptr_q[grant]];
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ca;
    logic [PTR_W-1:0]  p;
    ca = '0;
    p  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      ca              = bus.core_addr[i*ADDR_W +: ADDR_W];
      core_rdata_d[i] = mem[ca];
`ifdef DMEM_RAW_FWD_EN
      // Walk oldest to newest so the newest matching entry overrides.
      for (int k = 0; k < WBUF_DEPTH; k++) begin
        p = rd_ptr_q[i] + PTR_W'(k);
        if (CNT_W'(k) < count_q[i] && fifo_addr_mem[i][p] == ca)
          core_rdata_d[i] = fifo_data_mem[i][p];
      end
`endif
    end
    host_rdata_d = mem[bus.host_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q         <= '0;
      overflow_q   <= '0;
      host_rdata_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        rd_ptr_q[i]     <= '0;
        wr_ptr_q[i]     <= '0;
        count_q[i]      <= '0;
        core_rdata_q[i] <= '0;
      end
    end else begin
      rr_q         <= rr_d;
      overflow_q   <= overflow_d;
      host_rdata_q <= host_rdata_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        rd_ptr_q[i]     <= rd_ptr_d[i];
        wr_ptr_q[i]     <= wr_ptr_d[i];
        count_q[i]      <= count_d[i];
        core_rdata_q[i] <= core_rdata_d[i];
      end
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && ram_we) mem[ram_waddr] <= ram_wdata;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rst && push[i]) begin
        fifo_addr_mem[i][wr_ptr_q[i]] <= bus.core_addr[i*ADDR_W +: ADDR_W];
        fifo_data_mem[i][wr_ptr_q[i]] <= bus.core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.core_rdata = '0;
    wbuf_empty     = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      bus.core_rdata[i*DATA_W +: DATA_W] = core_rdata_q[i];
      if (count_q[i] != '0) wbuf_empty = 1'b0;
    end
  end

  assign bus.host_rdata = host_rdata_q;
  assign overflow       = overflow_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_dmem_responder;
  localparam int NC    = 4;
  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();
  logic          wbuf_empty;
  logic [NC-1:0] overflow;

  dmem_responder #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .wbuf_empty (wbuf_empty),
    .overflow   (overflow)
  );

  // reference model: per-core write queues of {addr, data}, a word array, rr pointer
  logic [AW+DW-1:0] wq_m [NC][$];
  logic [DW-1:0]    ram_m [4096];
  bit               known_m [4096];
  int               rr_m;
  logic [NC-1:0]    ov_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] core_rd(input int i);
    return bus.core_rdata[i*DW +: DW];
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.core_wr_en = '0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.host_wr_en = 1'b0;
  endtask

  task automatic set_core(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit we);
    bus.core_addr[i*AW +: AW]  = a;
    bus.core_wdata[i*DW +: DW] = d;
    bus.core_wr_en[i]          = we;
  endtask

  task automatic set_host(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we);
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_wr_en = we;
  endtask

  // One clock: predict from current inputs, advance the model, clock, compare.
  task automatic step();
    logic [DW-1:0]    ec [NC];
    bit               ecv [NC];
    logic [DW-1:0]    eh;
    bit               ehv;
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    a;
    bit               popped [NC];
    int               g;
    eh  = '0;
    ehv = 1'b0;
    for (int i = 0; i < NC; i++) begin
      ec[i] = '0; ecv[i] = 1'b0; popped[i] = 1'b0;
    end
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        ecv[i] = 1'b1;
        wq_m[i].delete();
      end
      ehv  = 1'b1;
      rr_m = 0;
      ov_m = '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        a      = bus.core_addr[i*AW +: AW];
        ec[i]  = ram_m[a];
        ecv[i] = known_m[a];
`ifdef DMEM_RAW_FWD_EN
        foreach (wq_m[i][k]) begin
          if (wq_m[i][k][AW+DW-1:DW] == a) begin
            ec[i]  = wq_m[i][k][DW-1:0];
            ecv[i] = 1'b1;
          end
        end
`endif
      end
      eh  = ram_m[bus.host_addr];
      ehv = known_m[bus.host_addr];
      if (bus.host_wr_en) begin
        ram_m[bus.host_addr]   = bus.host_wdata;
        known_m[bus.host_addr] = 1'b1;
      end else begin
        g = -1;
        for (int k = 0; k < NC; k++)
          if (g < 0 && wq_m[(rr_m + k) % NC].size() > 0) g = (rr_m + k) % NC;
        if (g >= 0) begin
          e = wq_m[g].pop_front();
          ram_m[e[AW+DW-1:DW]]   = e[DW-1:0];
          known_m[e[AW+DW-1:DW]] = 1'b1;
          popped[g] = 1'b1;
          rr_m = (g + 1) % NC;
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (bus.core_wr_en[i]) begin
          if (wq_m[i].size() < DEPTH)
            wq_m[i].push_back({bus.core_addr[i*AW +: AW], bus.core_wdata[i*DW +: DW]});
          else
            ov_m[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++)
      if (ecv[i]) check($sformatf("core%0d_rdata", i), 32'(core_rd(i)), 32'(ec[i]));
    if (ehv) check("host_rdata", 32'(bus.host_rdata), 32'(eh));
    check("overflow", 32'(overflow), 32'(ov_m));
    begin
      bit all_empty;
      all_empty = 1'b1;
      for (int i = 0; i < NC; i++) if (wq_m[i].size() != 0) all_empty = 1'b0;
      check("wbuf_empty", 32'(wbuf_empty), 32'(all_empty));
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle_inputs();
    set_host(a, d, 1'b1);
    step();
    idle_inputs();
  endtask

  task automatic host_read(input logic [AW-1:0] a);
    idle_inputs();
    set_host(a, '0, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    rr_m = 0;
    ov_m = '0;

    // reset
    step();
    step();
    rst = 1'b1;
    check("rst_core0_rdata", 32'(core_rd(0)), 32'h0);
    check("rst_host_rdata", 32'(bus.host_rdata), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_wbuf_empty", 32'(wbuf_empty), 32'h1);
    host_write(12'h010, 12'hABC);
    host_read(12'h010);
    check("host_rd_010", 32'(bus.host_rdata), 32'hABC);

    // round-robin drain of one write per core
    idle_inputs();
    for (int i = 0; i < NC; i++) set_core(i, AW'(12'h100 + i), DW'(12'h111 * (i + 1)), 1'b1);
    step();
    idle_inputs();
    for (int k = 0; k < NC; k++) begin
      step();
      if (k == NC - 2) check("rr_not_empty", 32'(wbuf_empty), 32'h0);
    end
    check("rr_empty", 32'(wbuf_empty), 32'h1);
    host_read(12'h103);
    check("rr_rd_103", 32'(bus.host_rdata), 32'h444);

    // own-buffer forwarding with drain blocked by the host
    host_write(12'h020, 12'h123);
    host_write(12'h204, 12'h0AA);
    host_write(12'h301, 12'h0CC);
    host_write(12'h304, 12'h0BB);
    set_host(12'h7FF, 12'h000, 1'b1);
    set_core(2, 12'h020, 12'h5A5, 1'b1);
    step();
    set_core(2, 12'h020, 12'h000, 1'b0);
    set_core(1, 12'h020, 12'h000, 1'b0);
    step();
`ifdef DMEM_RAW_FWD_EN
    check("fwd_core2", 32'(core_rd(2)), 32'h5A5);
`else
    check("nofwd_core2", 32'(core_rd(2)), 32'h123);
`endif
    check("fwd_core1_old", 32'(core_rd(1)), 32'h123);

    // newest matching entry wins
    idle_inputs();
    set_host(12'h7FF, 12'h000, 1'b1);
    set_core(0, 12'h030, 12'h001, 1'b1);
    step();
    set_core(0, 12'h030, 12'h002, 1'b1);
    step();
    set_core(0, 12'h030, 12'h000, 1'b0);
    step();
`ifdef DMEM_RAW_FWD_EN
    check("newest_wins", 32'(core_rd(0)), 32'h002);
`endif
    idle_inputs();
    repeat (4) step();
    host_read(12'h030);
    check("newest_ram_030", 32'(bus.host_rdata), 32'h002);

    // overflow on a fifth write while draining is blocked
    idle_inputs();
    set_host(12'h7FF, 12'h000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      set_core(3, AW'(12'h200 + k), DW'(12'h300 + k), 1'b1);
      step();
    end
    check("ovf3_set", 32'(overflow[3]), 32'h1);
    idle_inputs();
    repeat (5) step();
    check("ovf3_sticky", 32'(overflow[3]), 32'h1);
    host_read(12'h203);
    check("ovf_ram_203", 32'(bus.host_rdata), 32'h303);
    host_read(12'h204);
    check("ovf_ram_204", 32'(bus.host_rdata), 32'h0AA);

    // push on full accepted when the head drains in the same cycle
    idle_inputs();
    set_host(12'h7FF, 12'h000, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      set_core(0, AW'(12'h300 + k), DW'(12'h400 + k), 1'b1);
      step();
    end
    idle_inputs();
    set_core(0, 12'h304, 12'h404, 1'b1);
    step();
    check("push_pop_ovf0", 32'(overflow[0]), 32'h0);
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_clears_bufs", 32'(wbuf_empty), 32'h1);
    repeat (3) step();
    host_read(12'h300);
    check("rst_ram_300", 32'(bus.host_rdata), 32'h400);
    host_read(12'h301);
    check("rst_ram_301", 32'(bus.host_rdata), 32'h0CC);
    host_read(12'h304);
    check("rst_ram_304", 32'(bus.host_rdata), 32'h0BB);

    // randomized traffic over a small address window to provoke hits and overflows
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      idle_inputs();
      set_host(AW'($urandom_range(0, 15)), DW'($urandom), ($urandom_range(0, 5) == 0));
      for (int i = 0; i < NC; i++)
        set_core(i, AW'($urandom_range(0, 15)), DW'($urandom), ($urandom_range(0, 1) == 1));
      step();
    end
    rst = 1'b1;
    idle_inputs();
    repeat (NC * DEPTH + 2) step();
    check("final_empty", 32'(wbuf_empty), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
